// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - serial frame receiver with SOF hunt, EOF check and word-drain buffer
//
// Recovers frames of the form: idle 0s, SOF 8'h5a, 2**data_width payload bits, EOF 8'h0f
// (all MSB first) and drains committed payloads as word_width-bit words over valid/ready.
//
// Ports:
//   s_clk     in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   datain    in   serial line, sampled every rising edge
//   rd_ready  in   consumer accepts rd_data this cycle
//   rd_valid  out  rd_data holds a committed word
//   rd_data   out  current word; first-received bits are the MSBs of word 0
//   frame_ok  out  1-cycle pulse: frame committed
//   frame_err out  1-cycle pulse: EOF mismatch, frame dropped
//   overrun   out  1-cycle pulse: good frame dropped because the buffer was busy
//   busy      out  high while receiving payload or checking EOF
module serial_receiver #(
    parameter int data_width = 5,
    parameter int word_width = 8
) (
    input  logic                  s_clk,
    input  logic                  rst_n,
    input  logic                  datain,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [word_width-1:0] rd_data,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int PAYLOAD = 2 ** data_width;
    localparam int N_WORDS = PAYLOAD / word_width;
    // Bit counter must cover both the payload range and the 8 EOF bits.
    localparam int CNT_W   = (data_width > 3) ? data_width : 3;
    localparam int WCNT_W  = $clog2(N_WORDS + 1);

    localparam logic [7:0] SOF = 8'h5a;
    localparam logic [7:0] EOF = 8'h0f;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        DATA    = 2'd1,
        EOF_CHK = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
    logic [PAYLOAD-1:0]   asm_q, asm_d;
    logic [PAYLOAD-1:0]   buf_q, buf_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic                 frame_ok_q, frame_ok_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic [7:0]           window;
    logic                 xfer;
    logic                 buf_free;
    logic                 commit;

    assign window = {shreg_q[6:0], datain};
    assign xfer   = rd_valid && rd_ready;
    // A commit on the same edge as the final transfer is accepted so rd_valid has no gap.
    assign buf_free = (wcnt_q == '0) || ((wcnt_q == WCNT_W'(1)) && xfer);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        asm_d       = asm_q;
        buf_d       = buf_q;
        wcnt_d      = wcnt_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        commit      = 1'b0;

        case (state_q)
            HUNT: begin
                shreg_d = window;
                if (window == SOF) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                asm_d    = {asm_q[PAYLOAD-2:0], datain};
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == CNT_W'(PAYLOAD - 1)) begin
                    state_d  = EOF_CHK;
                    bitcnt_d = '0;
                end
            end
            EOF_CHK: begin
                shreg_d  = window;
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == CNT_W'(7)) begin
                    state_d  = HUNT;
                    bitcnt_d = '0;
                    // Clearing the window keeps EOF bits from combining into a false SOF.
                    shreg_d  = '0;
                    if (window == EOF) begin
                        if (buf_free) begin
                            commit     = 1'b1;
                            frame_ok_d = 1'b1;
                        end else begin
                            overrun_d  = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = HUNT;
                shreg_d  = '0;
                bitcnt_d = '0;
            end
        endcase

        if (commit) begin
            buf_d  = asm_q;
            wcnt_d = WCNT_W'(N_WORDS);
        end else if (xfer) begin
            buf_d  = buf_q << word_width;
            wcnt_d = wcnt_q - WCNT_W'(1);
        end
    end

    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            asm_q       <= '0;
            buf_q       <= '0;
            wcnt_q      <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            asm_q       <= asm_d;
            buf_q       <= buf_d;
            wcnt_q      <= wcnt_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rd_valid  = (wcnt_q != '0);
    assign rd_data   = buf_q[PAYLOAD-1 -: word_width];
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == DATA) || (state_q == EOF_CHK);

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed self-checking bench for serial_receiver
module tb_serial_receiver;

    logic       s_clk;
    logic       rst_n;
    logic       datain;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       frame_ok;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor state, sampled on the falling edge
    int         cyc = 0;
    logic [7:0] wq[$];
    int         cq[$];
    int         ok_cnt = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    int         busy_cnt = 0;
    int         viol_cnt = 0;
    logic       prev_pulse = 1'b0;

    serial_receiver #(.data_width(5), .word_width(8)) dut (
        .s_clk    (s_clk),
        .rst_n    (rst_n),
        .datain   (datain),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial begin
        s_clk = 1'b0;
        forever #5 s_clk = ~s_clk;
    end

    always @(negedge s_clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (rd_valid && rd_ready) begin
                wq.push_back(rd_data);
                cq.push_back(cyc);
            end
            ok_cnt  = ok_cnt + int'(frame_ok);
            err_cnt = err_cnt + int'(frame_err);
            ovr_cnt = ovr_cnt + int'(overrun);
            if (busy) busy_cnt = busy_cnt + 1;
            if (int'(frame_ok) + int'(frame_err) + int'(overrun) > 1) viol_cnt = viol_cnt + 1;
            if ((frame_ok || frame_err || overrun) && prev_pulse) viol_cnt = viol_cnt + 1;
            prev_pulse = frame_ok || frame_err || overrun;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        cq.delete();
        ok_cnt   = 0;
        err_cnt  = 0;
        ovr_cnt  = 0;
        busy_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        datain = b;
        @(posedge s_clk);
        #1;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    // Sends SOF + payload + eof; rd_ready is raised just before bit index ready_at (-1: never)
    task automatic send_frame(input logic [31:0] payload, input logic [7:0] eof, input int ready_at);
        logic [47:0] bits;
        bits = {8'h5a, payload, eof};
        for (int i = 0; i < 48; i++) begin
            if (i == ready_at) rd_ready = 1'b1;
            send_bit(bits[47-i]);
        end
    endtask

    task automatic check_words(input string tag, input logic [31:0] exp, input int base);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_w%0d", tag, k), {24'h0, wq[base+k]}, {24'h0, exp[31-8*k -: 8]});
    endtask

    task automatic check_consec(input string tag);
        int gaps;
        gaps = 0;
        for (int i = 1; i < cq.size(); i++)
            if (cq[i] != cq[i-1] + 1) gaps = gaps + 1;
        check(tag, gaps, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        datain   = 1'b0;
        rd_ready = 1'b0;
        #1;
        check("rst_async_outs", {rd_valid, rd_data, frame_ok, frame_err, overrun, busy}, 0);
        @(posedge s_clk);
        @(posedge s_clk);
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_pulses", {frame_ok, frame_err, overrun}, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        send_idle(3);

        // T1: good frame
        clear_mon();
        rd_ready = 1'b1;
        send_idle(5);
        send_frame(32'hDEADBEEF, 8'h0f, -1);
        check("t1_frame_ok_latency", frame_ok, 1);
        check("t1_rd_valid_rise", rd_valid, 1);
        check("t1_first_word", rd_data, 8'hDE);
        check("t1_busy_idle", busy, 0);
        send_idle(8);
        check("t1_ok_cnt", ok_cnt, 1);
        check("t1_err_ovr", err_cnt + ovr_cnt, 0);
        check("t1_nwords", wq.size(), 4);
        check_words("t1", 32'hDEADBEEF, 0);
        check_consec("t1_consec");
        check("t1_valid_low", rd_valid, 0);

        // T2: bad EOF then good frame
        clear_mon();
        send_frame(32'h12345678, 8'h0e, -1);
        check("t2_frame_err", frame_err, 1);
        check("t2_no_valid", rd_valid, 0);
        send_idle(2);
        send_frame(32'hCAFEF00D, 8'h0f, -1);
        check("t2_good_ok", frame_ok, 1);
        send_idle(8);
        check("t2_err_cnt", err_cnt, 1);
        check("t2_ok_cnt", ok_cnt, 1);
        check("t2_nwords", wq.size(), 4);
        check_words("t2", 32'hCAFEF00D, 0);

        // T3: false SOF
        clear_mon();
        send_idle(4);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_idle(40);
        check("t3_busy_never", busy_cnt, 0);
        check("t3_no_pulses", ok_cnt + err_cnt + ovr_cnt, 0);
        check("t3_no_words", wq.size(), 0);

        // T4: overrun with rd_ready low
        clear_mon();
        rd_ready = 1'b0;
        send_frame(32'hA5A5A5A5, 8'h0f, -1);
        check("t4_a_ok", frame_ok, 1);
        send_frame(32'h3C3C3C3C, 8'h0f, -1);
        check("t4_b_overrun", overrun, 1);
        check("t4_b_not_ok", frame_ok, 0);
        check("t4_held_data", rd_data, 8'hA5);
        rd_ready = 1'b1;
        send_idle(8);
        check("t4_ok_cnt", ok_cnt, 1);
        check("t4_ovr_cnt", ovr_cnt, 1);
        check("t4_nwords", wq.size(), 4);
        check_words("t4", 32'hA5A5A5A5, 0);
        check("t4_valid_low", rd_valid, 0);

        // T5: last transfer of A on B's commit edge
        clear_mon();
        rd_ready = 1'b0;
        send_frame(32'h11223344, 8'h0f, -1);
        check("t5_a_ok", frame_ok, 1);
        send_frame(32'h3C3C3C3C, 8'h0f, 44);
        check("t5_b_ok", frame_ok, 1);
        check("t5_no_overrun", overrun, 0);
        check("t5_valid_cont", rd_valid, 1);
        send_idle(8);
        check("t5_ovr_cnt", ovr_cnt, 0);
        check("t5_nwords", wq.size(), 8);
        check_words("t5a", 32'h11223344, 0);
        check_words("t5b", 32'h3C3C3C3C, 4);
        check_consec("t5_consec");

        // T6: reset mid-payload with undrained words pending
        clear_mon();
        rd_ready = 1'b0;
        send_frame(32'h55AA55AA, 8'h0f, -1);
        check("t6_pre_ok", frame_ok, 1);
        send_idle(2);
        for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1 ^ (8'h5a >> (7 - i)) & 1'b0);
        send_idle(1);
        send_frame(32'hFFFFFFFF, 8'h0f, -1);
        check("t6_overrun_busy_buf", overrun, 1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h5a >> (7 - i)) & 8'h01) != 0);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check("t6_busy_mid", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", {rd_valid, rd_data, frame_ok, frame_err, overrun, busy}, 0);
        @(posedge s_clk);
        @(posedge s_clk);
        #1;
        check("t6_rst_hold", {rd_valid, rd_data, frame_ok, frame_err, overrun, busy}, 0);
        rst_n = 1'b1;
        clear_mon();
        rd_ready = 1'b1;
        send_idle(4);
        send_frame(32'h0000FFFF, 8'h0f, -1);
        check("t6_clean_ok", frame_ok, 1);
        send_idle(8);
        check("t6_ok_cnt", ok_cnt, 1);
        check("t6_err_ovr", err_cnt + ovr_cnt, 0);
        check("t6_nwords", wq.size(), 4);
        check_words("t6", 32'h0000FFFF, 0);

        check("pulse_exclusive", viol_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
